alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, giving the number of result-queue entries (power of two, >=2).
REQ-002 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_input_op  input  2  write target: 0 load A, 1 load B, 2 trigger, 3 load B and re-trigger.
REQ-005 i_data_valid  input  1  qualifies i_input_op/i_data for this cycle.
REQ-006 i_data  input  32  operand value, or opcode in [3:0] for trigger.
REQ-007 i_output_op  input  2  read view: 0 head result low, 1 head result high, 2 operand A, 3 operand B.
REQ-008 i_result_empty  input  1  pop request for the head entry.
REQ-009 o_result_valid  output  1  result queue non-empty.
REQ-010 o_result  output  32  combinational view selected by i_output_op.
REQ-011 o_result_flags  output  5  head entry flags {E,V,C,N,Z}.

Function
REQ-012 SHALL latch i_data into A (op 0) or B (op 1/3) on the edge where i_data_valid=1; no latch when i_data_valid=0.
REQ-013 Trigger (op 2) SHALL use opcode i_data[3:0] and record it as last_op; op 3 SHALL write B and issue last_op using the new B.
REQ-014 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR (amount B[4:0]), 8 MUL unsigned 32x32->64, 15 CLR; 9-14 illegal.
REQ-015 Opcodes 0-7 SHALL push one entry {hi=0, lo=result, flags} on the edge after the trigger edge (1-cycle latency).
REQ-016 MUL SHALL copy A,B into working registers at trigger, run shift-add for 32 cycles, and push its entry 33 edges after the trigger; A/B writes during MUL SHALL not affect it.
REQ-017 FSM states IDLE and MUL_BUSY; IDLE->MUL_BUSY on MUL trigger, MUL_BUSY->IDLE on the push edge.
REQ-018 Flags: Z = lo==0; N = lo[31]; C = ADD carry-out, SUB 1 when A<B unsigned, MUL 1 when hi!=0, else 0; V = signed overflow for ADD/SUB, else 0.
REQ-019 E SHALL be a sticky error bit copied into every pushed entry; set by trigger while MUL_BUSY (trigger ignored), illegal opcode (nothing pushed), or push into a full queue (new entry dropped).
REQ-020 CLR SHALL flush the queue, clear E, and abort any MUL in progress on the same edge; pushes nothing.
REQ-021 Pop SHALL occur only when i_result_empty=1, queue non-empty and i_output_op is 0 or 1; pop on empty or with view 2/3 SHALL be ignored without error.
REQ-022 Simultaneous push and pop with queue full SHALL complete both without setting E; with queue empty the pushed entry SHALL become head on the next edge.
REQ-023 Queue pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be strict FIFO.
REQ-024 o_result for views 0/1 and o_result_flags SHALL read 0 when the queue is empty.

Reset
REQ-025 While i_rst_n=0: A, B, last_op (ADD), working registers, E, queue pointers and count SHALL be 0, FSM IDLE, o_result_valid=0, o_result_flags=0.
REQ-026 Reset asserted mid-MUL SHALL abort it; no entry SHALL be pushed after release.
REQ-027 First edge after deassertion SHALL accept inputs normally.

Verification
REQ-028 A=0xFFFFFFFF, B=1, trigger ADD -> next cycle valid=1, lo=0x00000000, flags Z=1,C=1,V=0,N=0,E=0.
REQ-029 A=0x7FFFFFFF, B=1, ADD then op3 with B=2 -> two entries 0x80000000 (N=1,V=1) then 0x80000001, popped in order.
REQ-030 A=0x10000, B=0x10000, MUL; rewrite A=5 at cycle 3 -> entry at edge 33: hi=0x00000001, lo=0, C=1, Z=1; second trigger at cycle 10 ignored, E=1.
REQ-031 Fill FIFO_DEPTH entries, push one more -> count stays FIFO_DEPTH, later entries E=1; same-cycle push+pop while full -> no E change, count unchanged.
REQ-032 Opcode 12 -> no push, E set; then CLR -> valid=0, subsequent ADD entry E=0.
REQ-033 Assert i_rst_n=0 at MUL cycle 15 -> valid=0, no entry after release; A=3,B=4,SUB -> lo=0xFFFFFFFF, C=1, N=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined 32-bit ALU with a sequential shift-add multiplier and a small result queue.
// Results carry {E,V,C,N,Z} flags; E is a sticky error bit copied into each pushed entry.
module alu_pipe #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_input_op,
  input  logic        i_data_valid,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_output_op,
  input  logic        i_result_empty,
  output logic        o_result_valid,
  output logic [31:0] o_result,
  output logic [4:0]  o_result_flags
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t            state_reg;
  logic [31:0]       a_reg, b_reg;
  logic [3:0]        last_op_reg;
  logic [63:0]       mul_a_reg, acc_reg;
  logic [31:0]       mul_b_reg;
  logic [5:0]        mul_cnt_reg;
  logic              e_reg;
  logic              pend_valid_reg;
  logic [31:0]       pend_lo_reg;
  logic [3:0]        pend_flags_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              trig, busy, is_clr, busy_err, accept, illegal, alu_go, mul_go;
  logic [3:0]        trig_code;
  logic [31:0]       op_b, diff, alu_lo;
  logic [32:0]       sum33;
  logic              alu_c, alu_v;
  logic              mul_done, push_req, push, pop, full, empty, overflow;
  logic [68:0]       push_entry, head;
  logic [68:0]       entry_q [FIFO_DEPTH];

  // Op 3 re-issues the last opcode against the B value written on the same edge.
  assign trig      = i_data_valid && i_input_op[1];
  assign trig_code = (i_input_op == 2'd2) ? i_data[3:0] : last_op_reg;
  assign op_b      = (i_input_op == 2'd3) ? i_data : b_reg;
  assign busy      = (state_reg == MUL_BUSY);
  assign is_clr    = trig && (trig_code == 4'd15);
  assign busy_err  = trig && busy && !is_clr;
  assign accept    = trig && !busy && !is_clr;
  assign illegal   = accept && (trig_code >= 4'd9);
  assign alu_go    = accept && !trig_code[3];
  assign mul_go    = accept && (trig_code == 4'd8);

  assign sum33 = {1'b0, a_reg} + {1'b0, op_b};
  assign diff  = a_reg - op_b;

  always_comb begin
    alu_lo = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (trig_code[2:0])
      3'd0: begin
        alu_lo = sum33[31:0];
        alu_c  = sum33[32];
        alu_v  = (a_reg[31] == op_b[31]) && (sum33[31] != a_reg[31]);
      end
      3'd1: begin
        alu_lo = diff;
        alu_c  = (a_reg < op_b);
        alu_v  = (a_reg[31] != op_b[31]) && (diff[31] != a_reg[31]);
      end
      3'd2: alu_lo = a_reg & op_b;
      3'd3: alu_lo = a_reg | op_b;
      3'd4: alu_lo = a_reg ^ op_b;
      3'd5: alu_lo = a_reg << op_b[4:0];
      3'd6: alu_lo = a_reg >> op_b[4:0];
      3'd7: alu_lo = $signed(a_reg) >>> op_b[4:0];
    endcase
  end

  // A MUL push and an ALU push can never land on the same edge: triggers are refused while busy.
  assign mul_done   = busy && (mul_cnt_reg == 6'd32);
  assign push_req   = pend_valid_reg || mul_done;
  assign push_entry = mul_done
                    ? {e_reg, 1'b0, (acc_reg[63:32] != 32'd0), acc_reg[31], (acc_reg[31:0] == 32'd0), acc_reg}
                    : {e_reg, pend_flags_reg, 32'd0, pend_lo_reg};

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop      = i_result_empty && !empty && !i_output_op[1];
  assign push     = push_req && (!full || pop) && !is_clr;
  assign overflow = push_req && full && !pop;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [68:0] entry_reg;
      always_ff @(posedge i_clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi)))
          entry_reg <= push_entry;
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      last_op_reg    <= 4'd0;
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
      acc_reg        <= '0;
      mul_cnt_reg    <= '0;
      e_reg          <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_lo_reg    <= '0;
      pend_flags_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      if (i_data_valid && (i_input_op == 2'd0))
        a_reg <= i_data;
      if (i_data_valid && i_input_op[0])
        b_reg <= i_data;
      if (trig && (i_input_op == 2'd2) && !busy_err)
        last_op_reg <= i_data[3:0];

      pend_valid_reg <= alu_go;
      if (alu_go) begin
        pend_lo_reg    <= alu_lo;
        pend_flags_reg <= {alu_v, alu_c, alu_lo[31], (alu_lo == 32'd0)};
      end

      if (is_clr) begin
        state_reg  <= IDLE;
        e_reg      <= 1'b0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        e_reg <= e_reg | busy_err | illegal | overflow;
        if (push)
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);

        case (state_reg)
          IDLE: begin
            if (mul_go) begin
              mul_a_reg   <= {32'd0, a_reg};
              mul_b_reg   <= op_b;
              acc_reg     <= '0;
              mul_cnt_reg <= '0;
              state_reg   <= MUL_BUSY;
            end
          end
          MUL_BUSY: begin
            if (mul_done) begin
              state_reg <= IDLE;
            end else begin
              if (mul_b_reg[0])
                acc_reg <= acc_reg + mul_a_reg;
              mul_a_reg   <= mul_a_reg << 1;
              mul_b_reg   <= mul_b_reg >> 1;
              mul_cnt_reg <= mul_cnt_reg + 6'd1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign head           = entry_q[rd_ptr_reg];
  assign o_result_valid = !empty;
  assign o_result_flags = empty ? 5'd0 : head[68:64];

  always_comb begin
    o_result = '0;
    case (i_output_op)
      2'd0: o_result = empty ? 32'd0 : head[31:0];
      2'd1: o_result = empty ? 32'd0 : head[63:32];
      2'd2: o_result = a_reg;
      2'd3: o_result = b_reg;
    endcase
  end

endmodule
